// File: rtl/dm_ctrl_if.sv
// Request/response handshake bundle between a CPU MEM stage and the data-memory controller.
// The CPU side uses the master modport and the controller uses the slave modport.
interface dm_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_op;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_op, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_op, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_ctrl.sv
// Single-outstanding data-memory controller: byte-lane stores, sign/zero-extending loads,
// alignment/range checking and a programmable read latency behind valid/ready handshakes.
module dm_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rstn,
  dm_ctrl_if.slave  bus
);
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          WA_W    = ADDR_W - 2;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic              live;
  logic              accept;
  logic [WA_W-1:0]   waddr;
  logic [IDX_W-1:0]  idx;
  logic              err_p0;
  logic [31:0]       word_p0;
  logic [31:0]       load_p0;
  logic [31:0]       merge_p0;
  logic [31:0]       rdata_p1;
  logic              err_p1;
  logic [31:0]       mem [DEPTH];

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] lo,
                                           input logic [1:0] op, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = $signed(word[{lo, 3'b000} +: 8]);
    h = $signed(word[{lo[1], 4'b0000} +: 16]);
    r = word;
    if (op == 2'b00) begin
      if (uns) r = {24'd0, b};
      else     r = 32'(b);
    end else if (op == 2'b01) begin
      if (uns) r = {16'd0, h};
      else     r = 32'(h);
    end
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] lo, input logic [1:0] op);
    logic [31:0] r;
    r = old;
    case (op)
      2'b00:   r[{lo, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   r[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Accept stage: decode, check and read the addressed word combinationally
  always_comb begin
    waddr    = bus.req_addr[ADDR_W-1:2];
    idx      = IDX_W'(waddr);
    err_p0   = (bus.req_op == 2'b11)
            || (bus.req_op == 2'b01 && bus.req_addr[0])
            || (bus.req_op == 2'b10 && bus.req_addr[1:0] != 2'b00)
            || (32'(waddr) >= DEPTH_U);
    word_p0  = mem[idx];
    load_p0  = load_fmt(word_p0, bus.req_addr[1:0], bus.req_op, bus.req_unsigned);
    merge_p0 = store_merge(word_p0, bus.req_wdata, bus.req_addr[1:0], bus.req_op);
  end

  assign bus.req_ready = (state == IDLE) && live;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)
                 state_nxt = (err_p0 || bus.req_we || RD_LAT == 1) ? RESP : RD_WAIT;
      RD_WAIT: if (cnt == 2'd1) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 2'd0;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (accept)                cnt <= 2'(RD_LAT - 1);
      else if (state == RD_WAIT) cnt <= cnt - 2'd1;
    end
  end

  // Response stage: the load result is captured at accept and held until consumed
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_p1 <= (err_p0 || bus.req_we) ? 32'd0 : load_p0;
      err_p1   <= err_p0;
      if (bus.req_we && !err_p0) mem[idx] <= merge_p0;
    end
  end

  // Data registers are not reset, so outputs are masked outside RESP
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? rdata_p1 : 32'd0;
  assign bus.rsp_err   = bus.rsp_valid && err_p1;
endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised, handshaked data-memory controller. Next generation of the single-cycle data memory in the CPU's MEM stage.
- Adds the following on top of byte-lane stores:
  - configurable depth, address width and read latency;
  - byte/half/word loads with sign or zero extension;
  - alignment and range checking with an error response;
  - valid/ready request and response handshakes.
- Serves one transaction at a time. The CPU or a stall unit drives the request side and consumes the response.

Parameters:
- ADDR_W, 9: width of the byte address.
- DEPTH, 128: number of 32-bit words. Must satisfy DEPTH <= 2^(ADDR_W-2).
- RD_LAT, 1: read latency in cycles from accept to rsp_valid. Legal range 1..4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_op  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request was rejected (misaligned, illegal op, or out of range).

Interface decision: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rstn.

Behaviour:
- Reset (asserting rstn low, at any time):
  - FSM goes to IDLE immediately; req_ready, rsp_valid, rsp_err and rsp_rdata all 0.
  - req_ready goes to 1 on the first clk edge after rstn deasserts.
  - The in-flight transaction is dropped with no response.
  - Memory contents are not reset. A store accepted before reset stays committed.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE: req_ready = 1. Accept happens when req_valid && req_ready at a rising edge.
  - Accepted store, or any erroring request: go to RESP.
  - Accepted valid load with RD_LAT = 1: go to RESP.
  - Accepted valid load with RD_LAT > 1: go to RD_WAIT and load a counter with RD_LAT-1.
  - RD_WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready = 1, then go to IDLE.
  - req_ready = 0 in RD_WAIT and RESP. There is no pipelining, so the minimum is 2 cycles per transaction.
- Error checks, evaluated on the accept-cycle inputs:
  - req_op == 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr[ADDR_W-1:2] >= DEPTH.
  - On error: no memory write, rsp_err = 1, rsp_rdata = 0, response one cycle after accept regardless of RD_LAT.
- Store, committed on the accept edge:
  - word: writes all 32 bits;
  - half: addr[1] selects [15:0] or [31:16] from wdata[15:0];
  - byte: addr[1:0] selects lane [8k+7:8k] from wdata[7:0].
  - Other lanes are unchanged.
  - Response: rsp_err = 0, rsp_rdata = 0.
- Load:
  - The word is sampled at the accept edge and the pipeline holds it, so memory contents at accept time are returned.
  - Byte lane is chosen by addr[1:0]; half is chosen by addr[1].
  - Result is sign-extended from bit 7 or 15 unless req_unsigned = 1, in which case it is zero-extended.
  - Word loads ignore req_unsigned.
- Ordering: with a single outstanding transaction, a load following a store always sees the store.
- Inputs are don't-care outside the accept cycle.

Test Plan:
- sw 0x80FF7F01 at 0x20, then load from the same word:
  - lb 0x20 -> 0x00000001;
  - lb 0x23 -> 0xFFFFFF80;
  - lbu 0x23 -> 0x00000080;
  - lh 0x22 -> 0xFFFF80FF;
  - lhu 0x20 -> 0x00007F01;
  - lw 0x20 -> 0x80FF7F01.
  - rsp_err = 0 throughout.
- sb 0x??AB at 0x21, then sh 0x1234 at 0x22 -> lw 0x20 returns 0x1234AB01.
- lw 0x22, sh 0x21, and op = 11 at 0x24 -> each gives rsp_err = 1, rsp_rdata = 0, response 1 cycle after accept. lw 0x20 afterwards is unchanged.
- RD_LAT = 3, lw 0x20 -> rsp_valid rises exactly 3 cycles after accept. Hold rsp_ready low for 4 cycles -> rsp stays stable and req_ready stays 0. req_ready returns 1 the cycle after rsp_ready.
- ADDR_W = 10, DEPTH = 128: sw at 0x200 -> rsp_err = 1 and no wrap-around write, so lw 0x000 is unchanged.
- Drive rstn low during RD_WAIT -> rsp_valid is 0 at once. After release, no stale response appears and the next request is serviced normally.
